// File: rtl/rca_share_sched.sv
// rca_share_sched: round-robin scheduler of two add requests onto one shared 4-bit ripple-carry slice.
module rca_share_sched #(
  parameter int NSLICE = 4,
  localparam int W = 4 * NSLICE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_s,
  input  logic         add_cout,
  output logic         busy
);
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, state_d;
  logic [IW-1:0] idx;
  logic [W-1:0] op_a, op_b, sum;
  logic op_cin, carry, id, last_grant, g0, g1, last;
  // last_grant high means requester 0 wins a tie
  assign g0 = rst_n && state == IDLE && req0_valid && (!req1_valid || last_grant);
  assign g1 = rst_n && state == IDLE && req1_valid && (!req0_valid || !last_grant);
  assign req0_ready = g0;
  assign req1_ready = g1;
  assign last = idx == IW'(NSLICE - 1);
  assign busy = state != IDLE;
  assign rsp_valid = state == DONE;
  assign rsp_sum = sum;
  assign rsp_cout = carry;
  assign rsp_id = id;
  assign add_a = state == ADD ? op_a[4*idx +: 4] : 4'd0;
  assign add_b = state == ADD ? op_b[4*idx +: 4] : 4'd0;
  assign add_cin = state == ADD && (idx == '0 ? op_cin : carry);
  always_comb begin
    state_d = state;
    state_d = state == IDLE ? ((g0 || g1) ? ADD : IDLE) :
              state == ADD  ? (last ? DONE : ADD) :
                              (rsp_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      carry <= 1'b0;
      last_grant <= 1'b1;
      id <= 1'b0;
      sum <= '0;
      op_a <= '0;
      op_b <= '0;
      op_cin <= 1'b0;
    end else begin
      state <= state_d;
      if (g0 || g1) begin
        op_a <= g1 ? req1_a : req0_a;
        op_b <= g1 ? req1_b : req0_b;
        op_cin <= g1 ? req1_cin : req0_cin;
        id <= g1;
        idx <= '0;
      end
      if (state == ADD) begin
        sum[4*idx +: 4] <= add_s;
        carry <= add_cout;
        idx <= idx + 1'b1;
      end
      if (rsp_valid && rsp_ready) last_grant <= id;
    end
endmodule

// File: tb/tb_rca_share_sched.sv
// tb_rca_share_sched: directed checks of grant order, slice sequencing, latency, stall and reset abandon.
module tb_rca_share_sched;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, req0_cin = 1'b0, req1_cin = 1'b0, rsp_ready = 1'b1;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, add_cin, add_cout, busy;
  logic [15:0] rsp_sum;
  logic [3:0] add_a, add_b, add_s;
  int n_cmp = 0, n_err = 0;
  rca_share_sched #(.NSLICE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout), .busy(busy)
  );
  assign {add_cout, add_s} = add_a + add_b + 5'(add_cin);
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic gid, input logic [15:0] a, input logic [15:0] b, input logic c,
                    input logic [15:0] es, input logic ec, input int hold, input logic drop);
    #1;
    chk("grant_rdy0", req0_ready, 32'(gid == 1'b0));
    chk("grant_rdy1", req1_ready, 32'(gid == 1'b1));
    step();
    if (drop) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      chk("add_a", add_a, 32'(a[4*i +: 4]));
      chk("add_b", add_b, 32'(b[4*i +: 4]));
      if (i == 0) chk("add_cin0", add_cin, 32'(c));
      chk("add_busy", busy, 1);
      chk("add_rsp_valid", rsp_valid, 0);
      chk("add_rdy", {req0_ready, req1_ready}, 0);
      step();
    end
    rsp_ready = hold == 0;
    for (int h = 0; h < hold; h++) begin
      chk("stall_valid", rsp_valid, 1);
      chk("stall_sum", rsp_sum, 32'(es));
      chk("stall_rdy", {req0_ready, req1_ready}, 0);
      chk("stall_busy", busy, 1);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("done_valid", rsp_valid, 1);
    chk("done_sum", rsp_sum, 32'(es));
    chk("done_cout", rsp_cout, 32'(ec));
    chk("done_id", rsp_id, 32'(gid));
    chk("done_add", {add_a, add_b, add_cin}, 0);
    chk("done_rdy", {req0_ready, req1_ready}, 0);
    step();
    chk("idle_valid", rsp_valid, 0);
    chk("idle_busy", busy, 0);
  endtask
  initial begin
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2;
    chk("rst_rdy", {req0_ready, req1_ready}, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp", {rsp_sum, rsp_cout, rsp_id}, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #20 rst_n = 1'b1;
    step();
    chk("idle_add", {add_a, add_b, add_cin}, 0);
    req0_valid = 1'b1; req0_a = 16'h0006; req0_b = 16'h000C; req0_cin = 1'b0;
    op(1'b0, 16'h0006, 16'h000C, 1'b0, 16'h0012, 1'b0, 0, 1'b1);
    req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'h0001; req1_cin = 1'b0;
    op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0, 1'b1);
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0001; req0_cin = 1'b0;
    step();
    req0_valid = 1'b0;
    step();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", rsp_valid, 0);
    chk("arst_rsp", {rsp_sum, rsp_cout, rsp_id}, 0);
    chk("arst_add", {add_a, add_b, add_cin}, 0);
    #10 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_rst_valid", {rsp_valid, busy}, 0);
    end
    req0_valid = 1'b1; req0_a = 16'h000E; req0_b = 16'h0008; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0007; req1_b = 16'h000E; req1_cin = 1'b1;
    op(1'b0, 16'h000E, 16'h0008, 1'b0, 16'h0016, 1'b0, 0, 1'b0);
    op(1'b1, 16'h0007, 16'h000E, 1'b1, 16'h0016, 1'b0, 0, 1'b0);
    op(1'b0, 16'h000E, 16'h0008, 1'b0, 16'h0016, 1'b0, 3, 1'b1);
    req1_valid = 1'b1; req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 1'b1;
    op(1'b1, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rca_share_sched.md
RCA_SHARE_SCHED -- requirements
Module: rca_share_sched

Interface
REQ-001 SHALL have parameter: NSLICE, 4, number of 4-bit slices; operand width W = 4*NSLICE (16 at default).
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req0_valid  in  1; req0_ready  out  1; req0_a  in  W; req0_b  in  W; req0_cin  in  1  (requester 0).
REQ-005 SHALL have ports: req1_valid  in  1; req1_ready  out  1; req1_a  in  W; req1_b  in  W; req1_cin  in  1  (requester 1).
REQ-006 SHALL have ports: rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  1  winning requester; rsp_sum  out  W; rsp_cout  out  1.
REQ-007 SHALL have ports: add_a  out  4; add_b  out  4; add_cin  out  1; add_s  in  4; add_cout  in  1  (drive one shared external combinational 4-bit RCA).
REQ-008 SHALL have port: busy  out  1  high in any state other than IDLE.

Function
REQ-009 SHALL implement FSM with states IDLE, ADD, DONE.
REQ-010 IDLE: if one valid, grant it; if both valid, grant the requester not granted last (round-robin via last_grant register).
REQ-011 Granted reqN_ready SHALL be high combinationally in the IDLE cycle of the grant only; ready of the other requester and all readies outside IDLE SHALL be 0.
REQ-012 On grant, SHALL capture a, b, cin and id into internal registers, clear slice index to 0, go to ADD.
REQ-013 ADD: add_a/add_b SHALL be slice [4*idx+3:4*idx] of captured operands; add_cin SHALL be captured cin when idx=0, else carry register.
REQ-014 Each ADD cycle SHALL store add_s into sum slice idx, load carry register with add_cout, increment idx.
REQ-015 After exactly NSLICE ADD cycles SHALL go to DONE; rsp_cout = carry out of final slice.
REQ-016 Latency: grant in cycle T -> ADD in T+1..T+NSLICE -> rsp_valid high from T+NSLICE+1.
REQ-017 DONE: rsp_valid=1; rsp_sum, rsp_cout, rsp_id SHALL be stable until rsp_valid && rsp_ready.
REQ-018 On response handshake SHALL update last_grant to rsp_id and return to IDLE; no new grant in the handshake cycle.
REQ-019 In IDLE and DONE, add_a, add_b, add_cin SHALL be 0.
REQ-020 Valid deasserted by a requester before grant SHALL NOT be granted; requests are not queued.
REQ-021 Arithmetic SHALL be unsigned modulo 2^W with carry out in rsp_cout; full result {rsp_cout, rsp_sum} = a + b + cin.

Reset
REQ-022 rst_n low SHALL immediately force: state IDLE, rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0, busy 0, idx 0, carry 0, last_grant 1 (requester 0 wins first tie).
REQ-023 Reset during ADD or DONE SHALL abandon the operation; no response SHALL be produced for it after reset release.
REQ-024 Readies SHALL be 0 while rst_n is low.

Verification
REQ-025 req0 a=0x0006 b=0x000C cin=0 -> add_a sequence 6,0,0,0; rsp_valid 5 cycles after grant; rsp_sum=0x0012, rsp_cout=0, rsp_id=0.
REQ-026 req1 a=0xFFFF b=0x0001 cin=0 -> carry ripples across all 4 slices; rsp_sum=0x0000, rsp_cout=1, rsp_id=1.
REQ-027 req0 and req1 valid together after reset, held continuously -> grant order 0,1,0; req1 a=0x0007 b=0x000E cin=1 -> rsp_sum=0x0016.
REQ-028 rsp_ready low 3 cycles in DONE with a=0x000E b=0x0008 -> rsp_valid held, rsp_sum=0x0016 stable, no ready asserted, busy=1.
REQ-029 rst_n pulsed low during second ADD cycle -> outputs at reset values at once; after release, no rsp_valid until a new request.
REQ-030 a=0x8000 b=0x8000 cin=1 -> rsp_sum=0x0001, rsp_cout=1.
